// File: rtl/eye_proj_seq_if.sv
// -----------------------------------------------------------------------------
// eye_proj_seq_if
// Signal bundle between the eye-locator frame sequencer and its surroundings.
//   slave  : sequencer side (eye_proj_seq)
//   master : environment side (pixel source, peak engine, result consumer)
// Signals:
//   enable, per_frame_vsync, per_frame_clken   frame control / pixel timing
//   x_cnt, y_cnt                               current pixel position
//   clr_phase, pk1_search, pk2_search          row strobes to the projection engine
//   pk1_x/sum/cnt, pk2_x/sum/cnt               peak data from the engine
//   res_valid/res_ready, res_x1/x2, res_y1/y2  result handshake and payload
//   busy, overrun_cnt                          status
// -----------------------------------------------------------------------------
interface eye_proj_seq_if #(
    parameter int SUM_W = 16,
    parameter int CNT_W = 10
);
    logic             enable;
    logic             per_frame_vsync;
    logic             per_frame_clken;
    logic [10:0]      x_cnt;
    logic [10:0]      y_cnt;
    logic             clr_phase;
    logic             pk1_search;
    logic             pk2_search;
    logic [10:0]      pk1_x;
    logic [10:0]      pk2_x;
    logic [SUM_W-1:0] pk1_sum;
    logic [SUM_W-1:0] pk2_sum;
    logic [CNT_W-1:0] pk1_cnt;
    logic [CNT_W-1:0] pk2_cnt;
    logic             res_valid;
    logic             res_ready;
    logic [10:0]      res_x1;
    logic [10:0]      res_x2;
    logic [SUM_W-1:0] res_y1;
    logic [SUM_W-1:0] res_y2;
    logic             busy;
    logic [7:0]       overrun_cnt;

    modport slave (
        input  enable, per_frame_vsync, per_frame_clken,
        input  pk1_x, pk2_x, pk1_sum, pk2_sum, pk1_cnt, pk2_cnt, res_ready,
        output x_cnt, y_cnt, clr_phase, pk1_search, pk2_search,
        output res_valid, res_x1, res_x2, res_y1, res_y2, busy, overrun_cnt
    );

    modport master (
        output enable, per_frame_vsync, per_frame_clken,
        output pk1_x, pk2_x, pk1_sum, pk2_sum, pk1_cnt, pk2_cnt, res_ready,
        input  x_cnt, y_cnt, clr_phase, pk1_search, pk2_search,
        input  res_valid, res_x1, res_x2, res_y1, res_y2, busy, overrun_cnt
    );
endinterface

// File: rtl/eye_proj_seq.sv
// -----------------------------------------------------------------------------
// eye_proj_seq
// Frame-level sequencer for the column-projection eye locator. Tracks pixel
// position, strobes the RAM-clear and peak-search rows, snapshots both peaks at
// frame end and divides sum/cnt for each peak on one shared restoring divider.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    eye_proj_seq_if.slave (see interface header for the signal list)
// Build option:
//   EYE_PROJ_OVERRUN_CNT_EN  when defined, overrun_cnt counts dropped frames
//                            (saturating at 255); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module eye_proj_seq #(
    parameter int IMG_HDISP = 1280,
    parameter int IMG_VDISP = 720,
    parameter int SUM_W     = 16,
    parameter int CNT_W     = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    eye_proj_seq_if.slave  bus
);

    localparam int          BIT_W  = $clog2(SUM_W);
    localparam logic [10:0] X_LAST = 11'(IMG_HDISP - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_VDISP - 1);
    localparam logic [10:0] Y_PK1  = 11'(IMG_VDISP - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SUM_W - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitVs, StAccum, StCapture, StDiv1, StDiv2, StHold
    } state_t;

    state_t           r_state;
    logic             r_vsync;
    logic [10:0]      r_x;
    logic [10:0]      r_y;
    logic             r_busy;
    logic             r_valid;
    logic [10:0]      r_x1;
    logic [10:0]      r_x2;
    logic [SUM_W-1:0] r_y1;
    logic [SUM_W-1:0] r_y2;
    // Divider: r_quo starts as the dividend and shifts into the quotient.
    logic [SUM_W-1:0] r_quo;
    logic [SUM_W-1:0] r_rem;
    logic [SUM_W-1:0] r_dvs;
    logic [SUM_W-1:0] r_sum2;
    logic [CNT_W-1:0] r_cnt2;
    logic [BIT_W-1:0] r_bit;

    logic             w_vs_rise;
    logic             w_vs_fall;
    logic             w_acc_pix;
    logic [SUM_W:0]   w_shift;
    logic [SUM_W:0]   w_diff;
    logic             w_ge;
    logic [SUM_W-1:0] w_rem_nxt;
    logic [SUM_W-1:0] w_quo_nxt;
    logic [SUM_W-1:0] w_quo_res;

    assign w_vs_rise = bus.per_frame_vsync & ~r_vsync;
    assign w_vs_fall = ~bus.per_frame_vsync & r_vsync;

    // Remainder stays below the divisor, so the top bit of the difference is a
    // clean borrow flag.
    assign w_shift   = {r_rem, r_quo[SUM_W-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[SUM_W];
    assign w_rem_nxt = w_ge ? w_diff[SUM_W-1:0] : w_shift[SUM_W-1:0];
    assign w_quo_nxt = {r_quo[SUM_W-2:0], w_ge};
    // Zero divisor would otherwise give all ones.
    assign w_quo_res = (r_dvs == '0) ? '0 : w_quo_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_vsync <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_sum2  <= '0;
            r_cnt2  <= '0;
            r_bit   <= '0;
        end else begin
            r_vsync <= bus.per_frame_vsync;
            unique case (r_state)
                StIdle: begin
                    if (bus.enable) begin
                        r_state <= StWaitVs;
                        r_busy  <= 1'b1;
                    end
                end
                StWaitVs: begin
                    if (!bus.enable) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (w_vs_rise) begin
                        r_state <= StAccum;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                StAccum: begin
                    if (bus.per_frame_clken) begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            if (r_y != Y_LAST) r_y <= r_y + 11'd1;
                        end else begin
                            r_x <= r_x + 11'd1;
                        end
                    end
                    if (w_vs_fall) r_state <= StCapture;
                end
                StCapture: begin
                    r_x1    <= bus.pk1_x;
                    r_x2    <= bus.pk2_x;
                    r_quo   <= bus.pk1_sum;
                    r_dvs   <= SUM_W'(bus.pk1_cnt);
                    r_sum2  <= bus.pk2_sum;
                    r_cnt2  <= bus.pk2_cnt;
                    r_rem   <= '0;
                    r_bit   <= '0;
                    r_state <= StDiv1;
                end
                StDiv1: begin
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == BIT_LAST) begin
                        // Peak 1 done; reload the divider for peak 2.
                        r_y1    <= w_quo_res;
                        r_quo   <= r_sum2;
                        r_dvs   <= SUM_W'(r_cnt2);
                        r_rem   <= '0;
                        r_bit   <= '0;
                        r_state <= StDiv2;
                    end else begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                    end
                end
                StDiv2: begin
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == BIT_LAST) begin
                        r_y2    <= w_quo_res;
                        r_bit   <= '0;
                        r_valid <= 1'b1;
                        r_state <= StHold;
                    end else begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                    end
                end
                StHold: begin
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        if (bus.enable) begin
                            r_state <= StWaitVs;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EYE_PROJ_OVERRUN_CNT_EN
    logic       w_drop;
    logic [7:0] r_ovr;

    // A frame that starts while a result is still in flight is lost.
    assign w_drop = w_vs_rise & ((r_state == StCapture) | (r_state == StDiv1) |
                                 (r_state == StDiv2) | (r_state == StHold));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovr <= '0;
        end else if (w_drop && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

    assign bus.overrun_cnt = r_ovr;
`else
    assign bus.overrun_cnt = '0;
`endif

    assign w_acc_pix      = (r_state == StAccum) & bus.per_frame_clken;
    assign bus.clr_phase  = w_acc_pix & (r_y == 11'd0);
    assign bus.pk1_search = w_acc_pix & (r_y == Y_PK1);
    assign bus.pk2_search = w_acc_pix & (r_y == Y_LAST);

    assign bus.x_cnt     = r_x;
    assign bus.y_cnt     = r_y;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_valid;
    assign bus.res_x1    = r_x1;
    assign bus.res_x2    = r_x2;
    assign bus.res_y1    = r_y1;
    assign bus.res_y2    = r_y2;

endmodule

// File: tb/tb_eye_proj_seq.sv
// -----------------------------------------------------------------------------
// tb_eye_proj_seq
// Directed self-checking bench for eye_proj_seq with an 8x6 image.
// Honours EYE_PROJ_OVERRUN_CNT_EN for the expected overrun count.
// -----------------------------------------------------------------------------
module tb_eye_proj_seq;

    localparam int H  = 8;
    localparam int V  = 6;
    localparam int SW = 16;
    localparam int CW = 10;
`ifdef EYE_PROJ_OVERRUN_CNT_EN
    localparam int OVR_ON = 1;
`else
    localparam int OVR_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eye_proj_seq_if #(.SUM_W(SW), .CNT_W(CW)) bus ();

    eye_proj_seq #(
        .IMG_HDISP (H),
        .IMG_VDISP (V),
        .SUM_W     (SW),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_peaks(input int x1, input int s1, input int c1,
                             input int x2, input int s2, input int c2);
        bus.pk1_x   = 11'(x1);
        bus.pk1_sum = 16'(s1);
        bus.pk1_cnt = 10'(c1);
        bus.pk2_x   = 11'(x2);
        bus.pk2_sum = 16'(s2);
        bus.pk2_cnt = 10'(c2);
    endtask

    // vsync rise, then n clken pulses; vsync left high.
    task automatic run_pixels(input int n);
        bus.per_frame_vsync = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            bus.per_frame_clken = 1'b1;
            step();
        end
        bus.per_frame_clken = 1'b0;
    endtask

    // Drops vsync (cycle N) and checks res_valid rises exactly at N+34.
    task automatic end_frame(input string tag, input int y1, input int y2,
                             input int x1, input int x2);
        bus.per_frame_vsync = 1'b0;
        repeat (33) step();
        check_eq({tag, "_valid_n33"}, 32'(bus.res_valid), 0);
        step();
        check_eq({tag, "_valid_n34"}, 32'(bus.res_valid), 1);
        check_eq({tag, "_y1"}, 32'(bus.res_y1), 32'(y1));
        check_eq({tag, "_y2"}, 32'(bus.res_y2), 32'(y2));
        check_eq({tag, "_x1"}, 32'(bus.res_x1), 32'(x1));
        check_eq({tag, "_x2"}, 32'(bus.res_x2), 32'(x2));
    endtask

    initial begin
        bus.enable          = 1'b0;
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.res_ready       = 1'b0;
        set_peaks(0, 0, 0, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_valid", 32'(bus.res_valid), 0);
        check_eq("rst_x_cnt", 32'(bus.x_cnt), 0);
        check_eq("rst_y_cnt", 32'(bus.y_cnt), 0);
        check_eq("rst_y1", 32'(bus.res_y1), 0);
        check_eq("rst_x1", 32'(bus.res_x1), 0);
        check_eq("rst_ovr", 32'(bus.overrun_cnt), 0);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        step();
        check_eq("en_busy", 32'(bus.busy), 1);

        // Full frame: strobe rows and counter end values
        set_peaks(3, 1200, 10, 6, 700, 7);
        bus.per_frame_vsync = 1'b1;
        step();
        for (int p = 1; p <= 48; p++) begin
            bus.per_frame_clken = 1'b1;
            #1;
            check_eq($sformatf("clr_p%0d", p), 32'(bus.clr_phase), 32'(p <= 8));
            check_eq($sformatf("pk1_p%0d", p), 32'(bus.pk1_search), 32'(p >= 33 && p <= 40));
            check_eq($sformatf("pk2_p%0d", p), 32'(bus.pk2_search), 32'(p >= 41));
            step();
        end
        bus.per_frame_clken = 1'b0;
        #1;
        check_eq("pk2_no_clken", 32'(bus.pk2_search), 0);
        check_eq("frame_y_end", 32'(bus.y_cnt), 5);
        check_eq("frame_x_end", 32'(bus.x_cnt), 0);
        end_frame("f1", 120, 100, 3, 6);
        check_eq("hold_busy", 32'(bus.busy), 1);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check_eq("f1_ack_valid", 32'(bus.res_valid), 0);
        check_eq("f1_ack_busy", 32'(bus.busy), 1);

        // Zero divisor on peak 2
        set_peaks(5, 1000, 3, 1, 500, 0);
        run_pixels(5);
        check_eq("f2_x_cnt", 32'(bus.x_cnt), 5);
        end_frame("f2", 333, 0, 5, 1);

        // Two dropped frames while the result is held
        set_peaks(9, 9, 9, 9, 9, 9);
        for (int k = 0; k < 2; k++) begin
            bus.per_frame_vsync = 1'b1;
            step();
            bus.per_frame_vsync = 1'b0;
            step();
        end
        check_eq("ovr_valid", 32'(bus.res_valid), 1);
        check_eq("ovr_y1", 32'(bus.res_y1), 333);
        check_eq("ovr_y2", 32'(bus.res_y2), 0);
        check_eq("ovr_x1", 32'(bus.res_x1), 5);
        check_eq("ovr_x2", 32'(bus.res_x2), 1);
        check_eq("ovr_cnt", 32'(bus.overrun_cnt), 32'(2 * OVR_ON));
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check_eq("ovr_ack_valid", 32'(bus.res_valid), 0);
        check_eq("ovr_ack_busy", 32'(bus.busy), 1);

        // Reset in the middle of DIV1
        set_peaks(4, 4000, 8, 2, 100, 4);
        run_pixels(3);
        bus.per_frame_vsync = 1'b0;
        step();
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_valid", 32'(bus.res_valid), 0);
        check_eq("mid_rst_y1", 32'(bus.res_y1), 0);
        check_eq("mid_rst_x1", 32'(bus.res_x1), 0);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        check_eq("mid_rst_ovr", 32'(bus.overrun_cnt), 0);
        rst_n = 1'b1;
        step();
        check_eq("recover_busy", 32'(bus.busy), 1);
        set_peaks(7, 2000, 9, 2, 65535, 1);
        run_pixels(10);
        check_eq("f4_y_cnt", 32'(bus.y_cnt), 1);
        end_frame("f4", 222, 65535, 7, 2);

        // vs_rise together with res_ready in HOLD: leave, count the drop
        bus.per_frame_vsync = 1'b1;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check_eq("sim_valid", 32'(bus.res_valid), 0);
        check_eq("sim_busy", 32'(bus.busy), 1);
        check_eq("sim_ovr", 32'(bus.overrun_cnt), 32'(OVR_ON));
        bus.per_frame_vsync = 1'b0;
        bus.enable = 1'b0;
        step();
        check_eq("dis_busy", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
